mem_stage_hs: RTL and testbench

Parametrised MEM stage for the 5-stage RISC-V pipeline. It replaces the fixed single-cycle data-memory instance with a req/ack handshake to an external variable-latency data memory. It adds byte-lane store strobes, load alignment with sign/zero extension, misalignment detection, and a stall output that holds the EX/MEM register. It sits between the EX/MEM pipeline register and the WB stage and registers all MEM/WB outputs.

---
 rtl/mem_stage_hs.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_mem_stage_hs.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_hs.sv
// MEM stage with a req/ack handshake to a variable-latency data memory.
// Formats store data and strobes, extends load data and detects misaligned
// accesses. StallM holds the upstream pipeline while an access is in flight.
// All MEM/WB outputs are registered.
module mem_stage_hs #(
  parameter int XLEN   = 64,
  parameter int NBYTES = XLEN / 8,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic              MemtoRegM,
  input  logic [1:0]        MemTypeM,
  input  logic              MemUnsignedM,
  input  logic [XLEN-1:0]   ALU_ResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [REG_W-1:0]  RD_M,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [NBYTES-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic              MisalignW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [XLEN-1:0]   ALU_ResultW,
  output logic [REG_W-1:0]  RD_W
);

  localparam int LANE_W = $clog2(NBYTES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Replicate the low byte/half/word of the store data across the whole word.
  function automatic logic [XLEN-1:0] store_replicate(input logic [1:0] size,
                                                      input logic [XLEN-1:0] data);
    logic [XLEN-1:0] r;
    case (size)
      2'b00:   r = {NBYTES{data[7:0]}};
      2'b01:   r = {(NBYTES / 2){data[15:0]}};
      2'b10:   r = {(NBYTES / 4){data[31:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  // Contiguous byte-enable run for the access size, shifted to its lane.
  function automatic logic [NBYTES-1:0] store_strobe(input logic [1:0] size,
                                                     input logic [LANE_W-1:0] lane);
    logic [7:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return NBYTES'(base) << lane;
  endfunction

  // Align the addressed bytes to bit 0, truncate to size, then extend.
  function automatic logic [XLEN-1:0] load_extend(input logic [1:0] size,
                                                  input logic uns,
                                                  input logic [LANE_W-1:0] lane,
                                                  input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            sign;
    sh = rdata >> {lane, 3'b000};
    case (size)
      2'b00: begin
        mask = XLEN'(8'hFF);
        sign = sh[7];
      end
      2'b01: begin
        mask = XLEN'(16'hFFFF);
        sign = sh[15];
      end
      2'b10: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sign = sh[31];
      end
      default: begin
        mask = {XLEN{1'b1}};
        sign = 1'b0;
      end
    endcase
    return (sh & mask) | ((sign & ~uns) ? ~mask : {XLEN{1'b0}});
  endfunction

  // Address not a multiple of the access size, or a doubleword on a 32-bit core.
  function automatic logic addr_misaligned(input logic [1:0] size, input logic [2:0] low);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = low[0];
      2'b10:   m = |low[1:0];
      default: m = (|low) | (XLEN == 32);
    endcase
    return m;
  endfunction

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [XLEN-1:0]     mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
  logic [NBYTES-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                regwrite_q, regwrite_d;
  logic                memtoreg_q, memtoreg_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic [XLEN-1:0]     alu_q, alu_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                is_load_q, is_load_d;
  logic                valid_w_q, valid_w_d;
  logic                regwrite_w_q, regwrite_w_d;
  logic                memtoreg_w_q, memtoreg_w_d;
  logic                misalign_w_q, misalign_w_d;
  logic [XLEN-1:0]     read_data_w_q, read_data_w_d;
  logic [XLEN-1:0]     alu_result_w_q, alu_result_w_d;
  logic [REG_W-1:0]    rd_w_q, rd_w_d;

  logic                acc_s;
  logic                misaligned_s;
  logic [LANE_W-1:0]   lane_s;
  logic                stall_s;

  assign acc_s        = ValidM & (MemReadM | MemWriteM);
  assign misaligned_s = acc_s & addr_misaligned(MemTypeM, ALU_ResultM[2:0]);
  assign lane_s       = ALU_ResultM[LANE_W-1:0];

  // Stall while an aligned access is being launched or awaiting its ack; never during reset.
  always_comb begin
    stall_s = 1'b0;
    if (!reset) begin
      stall_s = 1'b0;
    end else if (state_q == IDLE) begin
      stall_s = acc_s & ~misaligned_s;
    end else begin
      stall_s = ~mem_ack;
    end
  end

  assign StallM = stall_s;

  // Next-state, request launch and MEM/WB result selection.
  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_wstrb_d    = mem_wstrb_q;
    regwrite_d     = regwrite_q;
    memtoreg_d     = memtoreg_q;
    rd_d           = rd_q;
    alu_d          = alu_q;
    size_d         = size_q;
    uns_d          = uns_q;
    lane_d         = lane_q;
    is_load_d      = is_load_q;
    valid_w_d      = 1'b0;
    regwrite_w_d   = 1'b0;
    memtoreg_w_d   = 1'b0;
    misalign_w_d   = 1'b0;
    read_data_w_d  = {XLEN{1'b0}};
    alu_result_w_d = {XLEN{1'b0}};
    rd_w_d         = {REG_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (acc_s && !misaligned_s) begin
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = MemWriteM;
          mem_addr_d  = {ALU_ResultM[XLEN-1:LANE_W], {LANE_W{1'b0}}};
          mem_wdata_d = MemWriteM ? store_replicate(MemTypeM, WriteDataM) : {XLEN{1'b0}};
          mem_wstrb_d = MemWriteM ? store_strobe(MemTypeM, lane_s) : {NBYTES{1'b0}};
          regwrite_d  = RegWriteM;
          memtoreg_d  = MemtoRegM;
          rd_d        = RD_M;
          alu_d       = ALU_ResultM;
          size_d      = MemTypeM;
          uns_d       = MemUnsignedM;
          lane_d      = lane_s;
          is_load_d   = MemReadM;
        end else begin
          // Non-memory op, bubble or misaligned access passes straight to WB.
          valid_w_d      = ValidM;
          regwrite_w_d   = ValidM & RegWriteM & ~misaligned_s;
          memtoreg_w_d   = ValidM & MemtoRegM;
          misalign_w_d   = misaligned_s;
          alu_result_w_d = ALU_ResultM;
          rd_w_d         = RD_M;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d        = IDLE;
          mem_req_d      = 1'b0;
          valid_w_d      = 1'b1;
          regwrite_w_d   = regwrite_q;
          memtoreg_w_d   = memtoreg_q;
          alu_result_w_d = alu_q;
          rd_w_d         = rd_q;
          read_data_w_d  = is_load_q ? load_extend(size_q, uns_q, lane_q, mem_rdata)
                                     : {XLEN{1'b0}};
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State, memory-interface and MEM/WB registers; reset aborts any access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= {XLEN{1'b0}};
      mem_wdata_q    <= {XLEN{1'b0}};
      mem_wstrb_q    <= {NBYTES{1'b0}};
      regwrite_q     <= 1'b0;
      memtoreg_q     <= 1'b0;
      rd_q           <= {REG_W{1'b0}};
      alu_q          <= {XLEN{1'b0}};
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      lane_q         <= {LANE_W{1'b0}};
      is_load_q      <= 1'b0;
      valid_w_q      <= 1'b0;
      regwrite_w_q   <= 1'b0;
      memtoreg_w_q   <= 1'b0;
      misalign_w_q   <= 1'b0;
      read_data_w_q  <= {XLEN{1'b0}};
      alu_result_w_q <= {XLEN{1'b0}};
      rd_w_q         <= {REG_W{1'b0}};
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wstrb_q    <= mem_wstrb_d;
      regwrite_q     <= regwrite_d;
      memtoreg_q     <= memtoreg_d;
      rd_q           <= rd_d;
      alu_q          <= alu_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      lane_q         <= lane_d;
      is_load_q      <= is_load_d;
      valid_w_q      <= valid_w_d;
      regwrite_w_q   <= regwrite_w_d;
      memtoreg_w_q   <= memtoreg_w_d;
      misalign_w_q   <= misalign_w_d;
      read_data_w_q  <= read_data_w_d;
      alu_result_w_q <= alu_result_w_d;
      rd_w_q         <= rd_w_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign ValidW      = valid_w_q;
  assign RegWriteW   = regwrite_w_q;
  assign MemtoRegW   = memtoreg_w_q;
  assign MisalignW   = misalign_w_q;
  assign ReadDataW   = read_data_w_q;
  assign ALU_ResultW = alu_result_w_q;
  assign RD_W        = rd_w_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: table of operations against a 64-bit instance with a
// WB scoreboard, plus hand-written reset-abort and 32-bit sequences.
module tb_mem_stage_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ValidM, RegWriteM, MemWriteM, MemReadM, MemtoRegM, MemUnsignedM;
  logic [1:0]  MemTypeM;
  logic [63:0] ALU_ResultM, WriteDataM;
  logic [4:0]  RD_M;
  logic        StallM, mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;
  logic        ValidW, RegWriteW, MemtoRegW, MisalignW;
  logic [63:0] ReadDataW, ALU_ResultW;
  logic [4:0]  RD_W;

  logic        s_ValidM, s_RegWriteM, s_MemWriteM, s_MemReadM, s_MemtoRegM, s_MemUnsignedM;
  logic [1:0]  s_MemTypeM;
  logic [31:0] s_ALU_ResultM, s_WriteDataM;
  logic [4:0]  s_RD_M;
  logic        s_StallM, s_mem_req, s_mem_we, s_mem_ack;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [3:0]  s_mem_wstrb;
  logic        s_ValidW, s_RegWriteW, s_MemtoRegW, s_MisalignW;
  logic [31:0] s_ReadDataW, s_ALU_ResultW;
  logic [4:0]  s_RD_W;

  mem_stage_hs #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .MemtoRegM(MemtoRegM),
    .MemTypeM(MemTypeM), .MemUnsignedM(MemUnsignedM), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .RD_M(RD_M), .StallM(StallM), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ValidW(ValidW), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .MisalignW(MisalignW), .ReadDataW(ReadDataW),
    .ALU_ResultW(ALU_ResultW), .RD_W(RD_W)
  );

  mem_stage_hs #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .ValidM(s_ValidM), .RegWriteM(s_RegWriteM),
    .MemWriteM(s_MemWriteM), .MemReadM(s_MemReadM), .MemtoRegM(s_MemtoRegM),
    .MemTypeM(s_MemTypeM), .MemUnsignedM(s_MemUnsignedM), .ALU_ResultM(s_ALU_ResultM),
    .WriteDataM(s_WriteDataM), .RD_M(s_RD_M), .StallM(s_StallM), .mem_req(s_mem_req),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_wstrb(s_mem_wstrb), .mem_rdata(s_mem_rdata), .mem_ack(s_mem_ack),
    .ValidW(s_ValidW), .RegWriteW(s_RegWriteW), .MemtoRegW(s_MemtoRegW),
    .MisalignW(s_MisalignW), .ReadDataW(s_ReadDataW), .ALU_ResultW(s_ALU_ResultW),
    .RD_W(s_RD_W)
  );

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        misalign;
    logic [63:0] rdata;
    logic [63:0] alu;
    logic [4:0]  rd;
  } wexp_t;

  typedef struct {
    logic        valid, rw, mw, mr, m2r, uns;
    logic [1:0]  typ;
    logic [63:0] addr, wdata;
    logic [4:0]  rd;
    int          lat;
    logic [63:0] rdata;
    logic        exp_req, exp_we;
    logic [63:0] exp_addr, exp_wdata;
    logic [7:0]  exp_wstrb;
    int          exp_stall;
    logic        exp_valid;
    wexp_t       w;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  int    cur_id = 0;
  bit    mon_en = 1'b0;
  wexp_t sb_q[$];
  vec_t  vecs[$];

  task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (case %0d): actual %h required %h", what, cur_id, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, rw, mw, mr, m2r, uns, input logic [1:0] typ,
                              input logic [63:0] addr, wdata, input logic [4:0] rd,
                              input int lat, input logic [63:0] rdata,
                              input logic ereq, ewe, input logic [63:0] eaddr, ewdata,
                              input logic [7:0] ewstrb, input int estall,
                              input logic evalid, erw, em2r, emis, input logic [63:0] erdata);
    vec_t v;
    v.valid = valid; v.rw = rw; v.mw = mw; v.mr = mr; v.m2r = m2r; v.uns = uns;
    v.typ = typ; v.addr = addr; v.wdata = wdata; v.rd = rd; v.lat = lat; v.rdata = rdata;
    v.exp_req = ereq; v.exp_we = ewe; v.exp_addr = eaddr; v.exp_wdata = ewdata;
    v.exp_wstrb = ewstrb; v.exp_stall = estall; v.exp_valid = evalid;
    v.w = '{regwrite: erw, memtoreg: em2r, misalign: emis, rdata: erdata, alu: addr, rd: rd};
    return v;
  endfunction

  // WB scoreboard: every valid WB slot must match the oldest pending expectation.
  always @(negedge clk) begin
    if (mon_en && ValidW) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ValidW", 64'(ValidW), 64'd0);
      end else begin
        wexp_t e;
        wexp_t a;
        e = sb_q.pop_front();
        a = '{regwrite: RegWriteW, memtoreg: MemtoRegW, misalign: MisalignW,
              rdata: ReadDataW, alu: ALU_ResultW, rd: RD_W};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL wb_result (case %0d): actual rw=%0b m2r=%0b mis=%0b rdata=%h alu=%h rd=%0d required rw=%0b m2r=%0b mis=%0b rdata=%h alu=%h rd=%0d",
                   cur_id, a.regwrite, a.memtoreg, a.misalign, a.rdata, a.alu, a.rd,
                   e.regwrite, e.memtoreg, e.misalign, e.rdata, e.alu, e.rd);
        end
      end
    end
  end

  // Drive one operation, act as the memory, and count stall cycles.
  task automatic run_vec(input vec_t v, input int id);
    int stalls = 0;
    int busy = 0;
    bit done = 1'b0;
    bit req_seen = 1'b0;
    cur_id = id;
    ValidM = v.valid; RegWriteM = v.rw; MemWriteM = v.mw; MemReadM = v.mr;
    MemtoRegM = v.m2r; MemUnsignedM = v.uns; MemTypeM = v.typ;
    ALU_ResultM = v.addr; WriteDataM = v.wdata; RD_M = v.rd;
    if (v.exp_valid) sb_q.push_back(v.w);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        busy++;
        req_seen = 1'b1;
        chk("mem_we", 64'(mem_we), 64'(v.exp_we));
        chk("mem_addr", mem_addr, v.exp_addr);
        chk("mem_wstrb", 64'(mem_wstrb), 64'(v.exp_wstrb));
        if (v.exp_we) chk("mem_wdata", mem_wdata, v.exp_wdata);
        mem_ack = (busy == v.lat);
        mem_rdata = mem_ack ? v.rdata : {$urandom, $urandom};
      end
      #1;
      if (StallM) stalls++;
      else done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
    end
    if (!done) chk("stall_timeout", 64'd1, 64'd0);
    chk("stall_cycles", 64'(stalls), 64'(v.exp_stall));
    chk("req_issued", 64'(req_seen), 64'(v.exp_req));
    ValidM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; RegWriteM = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int occ;
    bit done;
    // Operation table (XLEN=64); stall count equals the BUSY cycle carrying the ack.
    //              v  rw mw mr m2r uns typ    addr            wdata                  rd lat rdata                 req we eaddr          ewdata                 wstrb  stl  vW rwW m2rW misW  erdata
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,64'h1234,64'h0,5'd7, 0,64'h0, 1'b0,1'b0,64'h0,64'h0,8'h00,0, 1'b1,1'b1,1'b0,1'b0,64'h0));
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,2'b00,64'h1003,64'h0,5'd5, 4,64'h0000_0000_8000_0000, 1'b1,1'b0,64'h1000,64'h0,8'h00,4, 1'b1,1'b1,1'b1,1'b0,64'hFFFF_FFFF_FFFF_FF80));
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,2'b00,64'h1003,64'h0,5'd6, 4,64'h0000_0000_8000_0000, 1'b1,1'b0,64'h1000,64'h0,8'h00,4, 1'b1,1'b1,1'b1,1'b0,64'h80));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,64'h2006,64'hBEEF,5'd0, 2,64'h0, 1'b1,1'b1,64'h2000,64'hBEEF_BEEF_BEEF_BEEF,8'hC0,2, 1'b1,1'b0,1'b0,1'b0,64'h0));
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,2'b10,64'h2002,64'h0,5'd9, 0,64'h0, 1'b0,1'b0,64'h0,64'h0,8'h00,0, 1'b1,1'b0,1'b1,1'b1,64'h0));
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,2'b01,64'h3002,64'h0,5'd10, 1,64'h1111_2222_8001_3333, 1'b1,1'b0,64'h3000,64'h0,8'h00,1, 1'b1,1'b1,1'b1,1'b0,64'hFFFF_FFFF_FFFF_8001));
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,2'b10,64'h4004,64'h0,5'd11, 3,64'h9ABC_DEF0_1234_5678, 1'b1,1'b0,64'h4000,64'h0,8'h00,3, 1'b1,1'b1,1'b1,1'b0,64'hFFFF_FFFF_9ABC_DEF0));
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,2'b11,64'h5000,64'h0,5'd12, 2,64'h0123_4567_89AB_CDEF, 1'b1,1'b0,64'h5000,64'h0,8'h00,2, 1'b1,1'b1,1'b1,1'b0,64'h0123_4567_89AB_CDEF));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,64'h6005,64'h1122_3344_5566_77A5,5'd0, 1,64'h0, 1'b1,1'b1,64'h6000,64'hA5A5_A5A5_A5A5_A5A5,8'h20,1, 1'b1,1'b0,1'b0,1'b0,64'h0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b10,64'h7004,64'hDEAD_BEEF_CAFE_F00D,5'd0, 1,64'h0, 1'b1,1'b1,64'h7000,64'hCAFE_F00D_CAFE_F00D,8'hF0,1, 1'b1,1'b0,1'b0,1'b0,64'h0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b11,64'h8008,64'h0102_0304_0506_0708,5'd0, 2,64'h0, 1'b1,1'b1,64'h8008,64'h0102_0304_0506_0708,8'hFF,2, 1'b1,1'b0,1'b0,1'b0,64'h0));
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,2'b11,64'h9004,64'h0,5'd14, 0,64'h0, 1'b0,1'b0,64'h0,64'h0,8'h00,0, 1'b1,1'b0,1'b1,1'b1,64'h0));
    vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,64'hA001,64'h1234,5'd0, 0,64'h0, 1'b0,1'b0,64'h0,64'h0,8'h00,0, 1'b1,1'b0,1'b0,1'b1,64'h0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'b10,64'hB000,64'h0,5'd15, 0,64'h0, 1'b0,1'b0,64'h0,64'h0,8'h00,0, 1'b0,1'b0,1'b0,1'b0,64'h0));
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,2'b01,64'hB006,64'h0,5'd13, 1,64'hF00D_0000_0000_0000, 1'b1,1'b0,64'hB000,64'h0,8'h00,1, 1'b1,1'b1,1'b1,1'b0,64'hF00D));

    // Reset with an aligned load presented: nothing issued, no stall.
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 64'h0;
    ValidM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; RegWriteM = 1'b1; MemtoRegM = 1'b1;
    MemUnsignedM = 1'b0; MemTypeM = 2'b10; ALU_ResultM = 64'h10; WriteDataM = 64'h0; RD_M = 5'd1;
    s_ValidM = 1'b0; s_RegWriteM = 1'b0; s_MemWriteM = 1'b0; s_MemReadM = 1'b0;
    s_MemtoRegM = 1'b0; s_MemUnsignedM = 1'b0; s_MemTypeM = 2'b00; s_ALU_ResultM = 32'h0;
    s_WriteDataM = 32'h0; s_RD_M = 5'd0; s_mem_ack = 1'b0; s_mem_rdata = 32'h0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_StallM", 64'(StallM), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    chk("rst_W_flags", {60'd0, ValidW, RegWriteW, MemtoRegW, MisalignW}, 64'd0);
    chk("rst_ReadDataW", ReadDataW, 64'd0);
    chk("rst_ALU_ResultW", ALU_ResultW, 64'd0);
    chk("rst_RD_W", 64'(RD_W), 64'd0);
    ValidM = 1'b0; MemReadM = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while BUSY aborts the access; a stale ack afterwards is ignored.
    cur_id = 100;
    ValidM = 1'b1; MemReadM = 1'b1; RegWriteM = 1'b1; MemtoRegM = 1'b1;
    MemTypeM = 2'b10; ALU_ResultM = 64'hC000; RD_M = 5'd20;
    @(posedge clk); @(negedge clk);
    chk("abort_req_up", 64'(mem_req), 64'd1);
    @(posedge clk); @(negedge clk);
    reset = 1'b0; ValidM = 1'b0; MemReadM = 1'b0; RegWriteM = 1'b0;
    #1;
    chk("abort_req_drop", 64'(mem_req), 64'd0);
    chk("abort_StallM", 64'(StallM), 64'd0);
    chk("abort_W_flags", {60'd0, ValidW, RegWriteW, MemtoRegW, MisalignW}, 64'd0);
    chk("abort_ReadDataW", ReadDataW, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    #1 chk("stale_ack_StallM", 64'(StallM), 64'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stale_ack_req", 64'(mem_req), 64'd0);
    chk("stale_ack_ValidW", 64'(ValidW), 64'd0);
    run_vec(vecs[1], 101);

    // 32-bit instance: doubleword is always misaligned; aligned word load occupies 2 cycles.
    cur_id = 200;
    s_ValidM = 1'b1; s_MemReadM = 1'b1; s_RegWriteM = 1'b1; s_MemtoRegM = 1'b1;
    s_MemTypeM = 2'b11; s_ALU_ResultM = 32'h8; s_RD_M = 5'd3;
    #1 chk("x32_dbl_StallM", 64'(s_StallM), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("x32_dbl_req", 64'(s_mem_req), 64'd0);
    chk("x32_dbl_W", {61'd0, s_ValidW, s_RegWriteW, s_MisalignW}, 64'b101);
    s_MemTypeM = 2'b10;
    occ = 0; done = 1'b0;
    for (int cyc = 0; cyc < 32 && !done; cyc++) begin
      occ++;
      s_mem_ack = 1'b0;
      if (s_mem_req) begin
        chk("x32_mem_addr", 64'(s_mem_addr), 64'h8);
        s_mem_ack = 1'b1;
        s_mem_rdata = 32'h8765_4321;
      end
      #1;
      if (!s_StallM) done = 1'b1;
      @(posedge clk); @(negedge clk);
      s_mem_ack = 1'b0;
    end
    chk("x32_occupancy", 64'(occ), 64'd2);
    chk("x32_ReadDataW", 64'(s_ReadDataW), 64'h8765_4321);
    chk("x32_W", {61'd0, s_ValidW, s_RegWriteW, s_MisalignW}, 64'b110);
    s_ValidM = 1'b0; s_MemReadM = 1'b0;

    repeat (2) @(negedge clk);
    cur_id = 300;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
